// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the accept-time fault check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

    // Illegal width code or misaligned address for the requested width.
    function automatic logic req_fault(input logic we, input logic [2:0] f3,
                                       input logic [1:0] byte_off);
        logic illegal;
        logic misaligned;
        illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                     (we && (f3 >= 3'b011));
        misaligned = (((f3 == F3_H) || (f3 == F3_HU)) && byte_off[0]) ||
                     ((f3 == F3_W) && (byte_off != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane handling: load extract with sign/zero extension, and the
// read-modify-write merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            byte_off,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] store_word
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted   = word >> {byte_off, 3'b000};
        load_data = '0;
        unique case (funct3)
            F3_B:    load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = word;
            F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        store_word = word;
        unique case (funct3)
            F3_B: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (byte_off[1]) store_word[31:16] = wdata[15:0];
                else             store_word[15:0]  = wdata[15:0];
            end
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit FSM: one request at a time, sub-word stores by
// read-modify-write against a word-wide memory with a single write enable.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_fault,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    lsu_state_t            state, state_next;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic                  accept;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_word;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .word       (mem_rd),
        .byte_off   (addr_q[1:0]),
        .funct3     (f3_q),
        .wdata      (mem_wd),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign mem_addr = addr_q[ADDR_WIDTH+1:2];

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_we     = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid) begin
                    if (req_fault(req_we, req_funct3, req_addr[1:0]))
                        state_next = RESP;
                    else if (req_we && (req_funct3 == F3_W))
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:  state_next = we_q ? WRITE : RESP;
            WRITE: begin
                mem_we     = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // mem_wd holds the raw store data from accept; a sub-word store overwrites
    // it with the merged word during READ so WRITE drives it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            mem_wd    <= '0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q   <= req_we;
                f3_q   <= req_funct3;
                addr_q <= req_addr;
                mem_wd <= req_wdata;
            end
            if ((state == READ) && we_q)
                mem_wd <= store_word;
            // Entering RESP straight from IDLE only happens on a fault.
            if (state_next == RESP) begin
                rsp_fault <= (state == IDLE);
                rsp_rdata <= ((state == READ) && !we_q) ? load_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed, table-driven bench for lsu_ctrl with a behavioural word memory.
module tb_lsu_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW+1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_fault;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    logic [DW-1:0] mem [32];
    logic          init_mem;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    assign mem_rd = mem[mem_addr];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem[3]  <= 32'h8899AABB;
            mem[31] <= 32'h80000000;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wd;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_we_cyc;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [6:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_fault, input int exp_lat,
                                input int exp_we_cyc, input logic [31:0] exp_wd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
        v.exp_we_cyc = exp_we_cyc; v.exp_wd = exp_wd;
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the IDLE
    // cycle following RESP so the next call issues back-to-back.
    task automatic run_vec(input vec_t v, input string tag);
        int          lat;
        int          we_cnt;
        int          we_cyc;
        logic        got;
        logic [31:0] wd;
        logic [31:0] held;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~v.we; req_funct3 = 3'b111;
        req_addr = ~v.addr; req_wdata = 32'hA5A5A5A5;
        lat = 0; we_cnt = 0; we_cyc = 0; got = 1'b0; wd = '0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (mem_we) begin
                we_cnt++; we_cyc = lat; wd = mem_wd;
            end
            if (rsp_valid) got = 1'b1;
        end
        check({tag, "_rsp_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, "_fault"}, 32'(rsp_fault), 32'(v.exp_fault));
        check({tag, "_we_count"}, 32'(we_cnt), (v.exp_we_cyc != 0) ? 32'd1 : 32'd0);
        if (v.exp_we_cyc != 0) begin
            check({tag, "_we_cycle"}, 32'(we_cyc), 32'(v.exp_we_cyc));
            check({tag, "_wd"}, wd, v.exp_wd);
        end
        held = rsp_rdata;
        @(negedge clk);
        check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rdata_hold"}, rsp_rdata, held);
    endtask

    initial begin
        rst_n = 1'b0; init_mem = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;

        //          we    f3      addr   wdata          rdata          flt lat wc wd
        vecs.push_back(mk(1'b0, 3'b000, 7'h0E, 32'h0,        32'hFFFFFF99, 0, 2, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b101, 7'h0C, 32'h0,        32'h0000AABB, 0, 2, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b001, 7'h0E, 32'h0,        32'hFFFF8899, 0, 2, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b100, 7'h0F, 32'h0,        32'h00000088, 0, 2, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 7'h0C, 32'h0,        32'h8899AABB, 0, 2, 0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b000, 7'h0D, 32'h123456CD, 32'h0,        0, 3, 2, 32'h8899CDBB));
        vecs.push_back(mk(1'b0, 3'b010, 7'h0C, 32'h0,        32'h8899CDBB, 0, 2, 0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b010, 7'h10, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 3'b010, 7'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b001, 7'h12, 32'h1111CAFE, 32'h0,        0, 3, 2, 32'hCAFEBEEF));
        vecs.push_back(mk(1'b0, 3'b001, 7'h12, 32'h0,        32'hFFFFCAFE, 0, 2, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 7'h06, 32'h0,        32'h0,        1, 1, 0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b001, 7'h03, 32'h0000FFFF, 32'h0,        1, 1, 0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b011, 7'h00, 32'h12345678, 32'h0,        1, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b110, 7'h00, 32'h0,        32'h0,        1, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 3'b000, 7'h7F, 32'h0,        32'hFFFFFF80, 0, 2, 0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b100, 7'h04, 32'h000000FF, 32'h0,        1, 1, 0, 32'h0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_fault", 32'(rsp_fault), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wd", mem_wd, 32'h0);
        init_mem = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Inputs without req_valid must be ignored.
        req_valid = 1'b0; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 7'h10; req_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("novalid%0d_we", i), 32'(mem_we), 32'd0);
            check($sformatf("novalid%0d_rsp", i), 32'(rsp_valid), 32'd0);
            check($sformatf("novalid%0d_ready", i), 32'(req_ready), 32'd1);
        end

        // Reset during the READ of an SH: no write, no response, memory intact.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 7'h0C; req_wdata = 32'h0000FFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst_in_read_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_rsp", 32'(rsp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midrst%0d_we", i), 32'(mem_we), 32'd0);
            check($sformatf("midrst%0d_rsp", i), 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("postrst%0d_we", i), 32'(mem_we), 32'd0);
            check($sformatf("postrst%0d_rsp", i), 32'(rsp_valid), 32'd0);
            check($sformatf("postrst%0d_ready", i), 32'(req_ready), 32'd1);
        end
        check("postrst_mem3", mem[3], 32'h8899CDBB);
        run_vec(mk(1'b0, 3'b010, 7'h0C, 32'h0, 32'h8899CDBB, 0, 2, 0, 32'h0), "postrst_lw");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit between the execute stage and the word-wide data memory.
- Accepts one RV32I load/store request at a time through a valid/ready handshake.
- Performs sub-word loads with sign/zero extension and sub-word stores via read-modify-write; the memory has one write enable and no byte enables.
- Flags misaligned or illegal requests and returns a one-cycle response to the pipeline.

Parameters:
- ADDR_WIDTH, 5: data-memory word-address width; byte address is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 32: memory word width; fixed at 32 for RV32I.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: LB=000, LH=001, LW=010, LBU=100, LHU=101; stores SB=000, SH=001, SW=010.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults.
- rsp_fault  out  1  misaligned or illegal funct3, qualified by rsp_valid.
- mem_addr  out  ADDR_WIDTH  word address, equal to the latched req_addr[ADDR_WIDTH+1:2].
- mem_wd  out  DATA_WIDTH  write data to memory.
- mem_we  out  1  memory write enable.
- mem_rd  in  DATA_WIDTH  combinational read data from the memory at mem_addr.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_we=0.
  - All latched request fields cleared; mem_addr=0, mem_wd=0.
- States: IDLE, READ, WRITE, RESP.
  - req_ready=1 only in IDLE.
  - mem_we=1 only in WRITE, decoded from the registered state.
- Accept: a transfer occurs on the clk edge where req_valid and req_ready are both 1. The unit latches we, funct3, addr and wdata.
- Fault check at accept:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal: funct3 011, 110 or 111, or a store with funct3>=011.
  - Fault path goes to RESP with rsp_fault=1 and no memory access.
- Loads: IDLE -> READ -> RESP.
  - In READ, the unit captures mem_rd and extracts the byte/halfword selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - rsp_valid rises 2 cycles after the accept edge.
- SW: IDLE -> WRITE -> RESP. mem_wd=wdata.
- SB/SH: IDLE -> READ -> WRITE -> RESP.
  - READ captures the old word.
  - WRITE drives the merged word: only the addressed byte lanes are replaced by wdata[7:0] or wdata[15:0]; other lanes are unchanged.
  - Latency 3 cycles.
- RESP: rsp_valid=1 for exactly one cycle, rsp_fault per check, then IDLE.
  - rsp_rdata and rsp_fault are registered and hold their value until the next RESP.
- Back-to-back: a new request can be accepted on the cycle after RESP (IDLE). Minimum issue interval is 3 cycles for loads and SW, 4 for SB/SH.
- req_valid deasserted while not ready: ignored; no request is latched.
- Input changes after accept: no effect, since all operands are latched.
- Reset mid-operation: the request is abandoned, mem_we drops immediately, and no response is generated. A write whose WRITE-state edge already occurred is complete.
- Address wrap: none. The byte address width exactly covers the memory.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum lsu_state_t {IDLE, READ, WRITE, RESP}.
- Sub-module lsu_align (combinational): load extract/extend from (word, addr[1:0], funct3) and store merge from (old word, wdata, addr[1:0], funct3).
- lsu_ctrl contains only the FSM and the registers.

Test Plan:
- Reset: mem word 3 = 0x8899AABB. LB at byte addr 0x0E -> rsp_valid at T+2; rsp_rdata=0xFFFFFF99, rsp_fault=0.
- LHU at 0x0C on the same word -> rsp_rdata=0x0000AABB. LH at 0x0E -> 0xFFFF8899.
- SB 0x123456CD at 0x0D on word 3:
  - mem_we high exactly one cycle (T+2) with mem_wd=0x8899CDBB.
  - rsp_valid at T+3; a subsequent LW 0x0C returns 0x8899CDBB.
- SW 0xDEADBEEF at 0x10 -> mem_we at T+1, rsp at T+2; LW 0x10 -> 0xDEADBEEF.
- Misaligned:
  - LW at 0x06 -> rsp_valid T+1, rsp_fault=1, rsp_rdata=0, mem_we never asserted.
  - SH at 0x03 behaves the same.
  - Store funct3=011 is likewise faulted.
- Reset mid-op: SH accepted, rst_n pulled low during READ:
  - No mem_we and no rsp_valid.
  - req_ready=1 after release; memory contents unchanged.
